// File: rtl/gray_ptr_ctrl.sv
// Gray-coded FIFO pointer with a registered full (MODE 0) or empty (MODE 1) flag for one async FIFO side.
// Optional macro GRAY_PTR_LEVEL_EN adds a registered occupancy estimate on Level.
module gray_ptr_ctrl #(
  parameter int Addr_width = 4,
  parameter int MODE       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Inc,
  input  logic [Addr_width:0]   Sync_gray_ptr,
  output logic [Addr_width-1:0] Addr,
  output logic [Addr_width:0]   Gray_ptr,
  output logic                  Flag,
  output logic [Addr_width:0]   Level
);

  localparam int AW = Addr_width;

  logic [AW:0] bin;
  logic [AW:0] bin_next;
  logic [AW:0] gray_next;
  logic        accept;
  logic        flag_next;

  assign accept    = Inc & ~Flag;
  assign bin_next  = bin + {{AW{1'b0}}, accept};
  assign gray_next = bin_next ^ (bin_next >> 1);
  assign Addr      = bin[AW-1:0];

  // Full is the other pointer one lap behind: in Gray that is the top two bits inverted.
  generate
    if (MODE == 0) begin : g_full
      assign flag_next = (gray_next == {~Sync_gray_ptr[AW:AW-1], Sync_gray_ptr[AW-2:0]});
    end else begin : g_empty
      assign flag_next = (gray_next == Sync_gray_ptr);
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bin      <= '0;
      Gray_ptr <= '0;
      Flag     <= (MODE != 0);
    end else begin
      bin      <= bin_next;
      Gray_ptr <= gray_next;
      Flag     <= flag_next;
    end
  end

`ifdef GRAY_PTR_LEVEL_EN
  logic [AW:0] sync_bin;
  logic [AW:0] level_next;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    sync_bin = '0;
    for (int i = 0; i <= AW; i++) begin
      sync_bin[i] = ^(Sync_gray_ptr >> i);
    end
  end

  assign level_next = (MODE == 0) ? (bin_next - sync_bin) : (sync_bin - bin_next);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Level <= '0;
    end else begin
      Level <= level_next;
    end
  end
`else
  assign Level = '0;
`endif

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Scoreboard bench: a write-side and a read-side instance (Addr_width=3) checked against a pointer-count model.
module tb_gray_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inc0 = 1'b0, inc1 = 1'b0;
  logic [3:0] sync0 = '0, sync1 = '0;
  logic [2:0] addr0, addr1;
  logic [3:0] gray0, gray1, lvl0, lvl1;
  logic       flag0, flag1;

  gray_ptr_ctrl #(.Addr_width(3), .MODE(0)) u_wr (
    .CLK(clk), .RST(rst), .Inc(inc0), .Sync_gray_ptr(sync0),
    .Addr(addr0), .Gray_ptr(gray0), .Flag(flag0), .Level(lvl0)
  );

  gray_ptr_ctrl #(.Addr_width(3), .MODE(1)) u_rd (
    .CLK(clk), .RST(rst), .Inc(inc1), .Sync_gray_ptr(sync1),
    .Addr(addr1), .Gray_ptr(gray1), .Flag(flag1), .Level(lvl1)
  );

  typedef struct {
    int addr0, gray0, flag0, lvl0;
    int addr1, gray1, flag1, lvl1;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: pointers are plain counts modulo 16; the other side's pointer is a count too.
  int m0_ptr = 0, m1_ptr = 0;
  int m0_flag = 0, m1_flag = 1;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #20;
    forever #5 clk = ~clk;
  end

  // One cycle of stimulus: drive at negedge, predict what the next posedge must produce.
  task automatic step(input bit i0, input int s0, input bit i1, input int s1);
    exp_t e;
    int   d0, d1;
    @(negedge clk);
    inc0  = i0;
    sync0 = 4'(to_gray(s0));
    inc1  = i1;
    sync1 = 4'(to_gray(s1));
    if (i0 && m0_flag == 0) m0_ptr = (m0_ptr + 1) % 16;
    if (i1 && m1_flag == 0) m1_ptr = (m1_ptr + 1) % 16;
    d0 = (m0_ptr - s0) & 15;   // entries written but not yet read
    d1 = (s1 - m1_ptr) & 15;   // entries available to read
    m0_flag = (d0 == 8) ? 1 : 0;
    m1_flag = (d1 == 0) ? 1 : 0;
    e.addr0 = m0_ptr % 8;
    e.gray0 = to_gray(m0_ptr);
    e.flag0 = m0_flag;
    e.addr1 = m1_ptr % 8;
    e.gray1 = to_gray(m1_ptr);
    e.flag1 = m1_flag;
`ifdef GRAY_PTR_LEVEL_EN
    e.lvl0 = d0;
    e.lvl1 = d1;
`else
    e.lvl0 = 0;
    e.lvl1 = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr0"}, addr0, 0);
    chk({tag, "_gray0"}, gray0, 0);
    chk({tag, "_flag0"}, flag0, 0);
    chk({tag, "_lvl0"},  lvl0,  0);
    chk({tag, "_addr1"}, addr1, 0);
    chk({tag, "_gray1"}, gray1, 0);
    chk({tag, "_flag1"}, flag1, 1);
    chk({tag, "_lvl1"},  lvl1,  0);
  endtask

  // Reset asserted away from any edge, with increments pending that must be discarded.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    rst = 1'b0;
    m0_ptr = 0; m1_ptr = 0; m0_flag = 0; m1_flag = 1;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("addr0", addr0, e.addr0);
      chk("gray0", gray0, e.gray0);
      chk("flag0", flag0, e.flag0);
      chk("lvl0",  lvl0,  e.lvl0);
      chk("addr1", addr1, e.addr1);
      chk("gray1", gray1, e.gray1);
      chk("flag1", flag1, e.flag1);
      chk("lvl1",  lvl1,  e.lvl1);
    end
  end

  initial begin
    int p1, p2;
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_noclk");
    #16;
    rst = 1'b0;

    // Fill the write side to full, run the read side up to a sync pointer of 4.
    for (int i = 0; i < 10; i++) step(1'b1, 0, 1'b1, 4);
    // Release full by moving the read pointer; the next increment is taken.
    for (int i = 0; i < 3; i++) step(1'b1, 1, 1'b0, 4);

    mid_reset("rst_mid");

    // Long run with the other side trailing by two cycles: wraps twice, never full.
    p1 = 0; p2 = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, p2, 1'b1, p2);
      p2 = p1;
      p1 = m0_ptr;
    end

    mid_reset("rst_lvl");
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b1, 8);
    for (int i = 0; i < 2; i++) step(1'b0, 2, 1'b0, 8);

    for (int i = 0; i < 300; i++) begin
      int s0, s1;
      s0 = (m0_ptr - int'($urandom_range(0, 8))) & 15;
      s1 = (m1_ptr + int'($urandom_range(0, 8))) & 15;
      step(1'($urandom_range(0, 1)), s0, 1'($urandom_range(0, 1)), s1);
    end

    @(posedge clk);
    #3;
    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
